rom_arbiter: RTL and testbench

- Round-robin arbiter that shares the single synchronous read port of one `rom` instance between R requesters.
- Each requester presents an address and a request. The arbiter drives the ROM address and returns the ROM word tagged with a one-hot valid to the winning requester.
- Sits between several consumers (sequencers, lookup users) and one ROM, so the ROM is instantiated once instead of per consumer.

---
 rtl/rom_arbiter.sv | 111 +++++++++++
 tb/tb_rom_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one synchronous ROM read port
// among R requesters.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   req       per-requester level-sensitive read request [R]
//   addr_i    packed request addresses, requester k at [k*aw +: aw]
//   gnt       registered one-hot grant [R]
//   rom_addr  registered address to the ROM [aw]
//   rom_data  ROM output word, 1-cycle latency from rom_addr [n]
//   data_o    returned word, combinational copy of rom_data [n]
//   valid_o   registered one-hot tag marking data_o's owner [R]
module rom_arbiter #(
    parameter  int unsigned R  = 4,
    parameter  int unsigned m  = 8,
    parameter  int unsigned n  = 4,
    localparam int unsigned aw = $clog2(m)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [R-1:0]    req,
    input  logic [R*aw-1:0] addr_i,
    output logic [R-1:0]    gnt,
    output logic [aw-1:0]   rom_addr,
    input  logic [n-1:0]    rom_data,
    output logic [n-1:0]    data_o,
    output logic [R-1:0]    valid_o
);

    localparam int unsigned PW = $clog2(R);
    localparam int unsigned SW = PW + 1;

    logic [R-1:0]  gnt_q, gnt_d;
    logic [R-1:0]  valid_q, valid_d;
    logic [aw-1:0] rom_addr_q, rom_addr_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic [R-1:0]  elig;
    logic [R-1:0]  rot;
    logic          found;
    logic [PW-1:0] offset;
    logic [SW-1:0] sum;
    logic [SW-1:0] nxt;
    logic [PW-1:0] win;
    logic [aw-1:0] addr_arr [R];

    // Unpack the per-requester address slices.
    always_comb begin
        for (int k = 0; k < R; k++) begin
            addr_arr[k] = addr_i[k*aw +: aw];
        end
    end

    // Winner selection and next-state computation.
    always_comb begin
        gnt_d      = '0;
        valid_d    = gnt_q;
        rom_addr_d = rom_addr_q;
        ptr_d      = ptr_q;
        found      = 1'b0;
        offset     = '0;

        // Last cycle's winner is masked so a held req is not double-granted.
        elig = req & ~gnt_q;
        // Rotate so bit 0 is the requester at ptr; first set bit is the winner.
        rot  = R'({elig, elig} >> ptr_q);

        for (int i = 0; i < R; i++) begin
            if (!found && rot[i]) begin
                found  = 1'b1;
                offset = PW'(i);
            end
        end

        sum = {1'b0, ptr_q} + {1'b0, offset};
        if (sum >= SW'(R)) begin
            sum = sum - SW'(R);
        end
        win = sum[PW-1:0];

        nxt = {1'b0, win} + SW'(1);

        if (found) begin
            gnt_d[win] = 1'b1;
            rom_addr_d = addr_arr[win];
            ptr_d      = (nxt == SW'(R)) ? '0 : nxt[PW-1:0];
        end
    end

    // State registers; reset also discards any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q      <= '0;
            valid_q    <= '0;
            rom_addr_q <= '0;
            ptr_q      <= '0;
        end else begin
            gnt_q      <= gnt_d;
            valid_q    <= valid_d;
            rom_addr_q <= rom_addr_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt      = gnt_q;
    assign valid_o  = valid_q;
    assign rom_addr = rom_addr_q;
    assign data_o   = rom_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: directed scenarios plus randomized traffic,
// checked by a cycle-level reference model and a response scoreboard.
module tb_rom_arbiter;

    localparam int R  = 4;
    localparam int M  = 8;
    localparam int N  = 4;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [R-1:0]    req;
    logic [R*AW-1:0] addr_i;
    logic [R-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [N-1:0]    rom_data;
    logic [N-1:0]    data_o;
    logic [R-1:0]    valid_o;

    rom_arbiter #(.R(R), .m(M), .n(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr_i   (addr_i),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .data_o   (data_o),
        .valid_o  (valid_o)
    );

    always #5 clk = ~clk;

    // ROM behaviour: registered read, contents 0..5 then two marker words.
    logic [N-1:0] rom_mem [M];
    initial begin
        for (int i = 0; i < 6; i++) rom_mem[i] = N'(i);
        rom_mem[6] = 4'hC;
        rom_mem[7] = 4'hD;
    end
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    typedef struct {
        int           idx;
        logic [N-1:0] data;
        int           due;
    } exp_t;

    exp_t sb [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration rules applied to sampled inputs each edge.
    int           cyc     = 0;
    bit           started = 0;
    int           m_ptr   = 0;
    int           m_last  = -1;
    logic [AW-1:0] m_addr = '0;
    logic [R-1:0] exp_gnt = '0;

    always @(posedge clk) begin
        int win;
        int c;
        cyc++;
        if (rst) begin
            m_ptr   = 0;
            m_last  = -1;
            m_addr  = '0;
            exp_gnt = '0;
            sb.delete();
            started = 1;
        end else begin
            win = -1;
            for (int k = 0; k < R; k++) begin
                c = (m_ptr + k) % R;
                if (win < 0 && req[c] && c != m_last) win = c;
            end
            if (win >= 0) begin
                exp_gnt = '0;
                exp_gnt[win] = 1'b1;
                m_addr  = addr_i[win*AW +: AW];
                m_ptr   = (win + 1) % R;
                sb.push_back('{win, rom_mem[m_addr], cyc + 1});
            end else begin
                exp_gnt = '0;
            end
            m_last = win;
        end
    end

    // Monitor: compares registered outputs and pops responses on valid_o.
    always @(negedge clk) begin
        exp_t e;
        logic [R-1:0] oh;
        if (started) begin
            check("gnt", 32'(gnt), 32'(exp_gnt));
            check("rom_addr", 32'(rom_addr), 32'(m_addr));
            if (valid_o != '0) begin
                if (sb.size() == 0) begin
                    check("valid_unexpected", 32'(valid_o), 32'h0);
                end else begin
                    e = sb.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    check("valid_o", 32'(valid_o), 32'(oh));
                    check("data_o", 32'(data_o), 32'(e.data));
                    check("valid_time", 32'(cyc), 32'(e.due));
                end
            end else begin
                while (sb.size() != 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    check("valid_missing", 32'(valid_o), 32'(1 << e.idx));
                end
            end
        end
    end

    task automatic drive(input logic r, input logic [R-1:0] rq,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                         input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rst    = r;
            req    = rq;
            addr_i = {a3, a2, a1, a0};
        end
    endtask

    initial begin
        rst    = 1'b1;
        req    = '1;
        addr_i = '0;

        // Reset held with all requests active.
        drive(1'b1, 4'b1111, 3'd1, 3'd2, 3'd4, 3'd5, 3);

        // Round robin over all four; first grant goes to requester 0.
        drive(1'b0, 4'b1111, 3'd1, 3'd2, 3'd4, 3'd5, 1);
        @(posedge clk);
        #1 check("first_grant_after_reset", 32'(gnt), 32'h1);
        drive(1'b0, 4'b1111, 3'd1, 3'd2, 3'd4, 3'd5, 6);

        // Single requester held: grant every second cycle.
        drive(1'b0, 4'b0010, 3'd0, 3'd3, 3'd0, 3'd0, 6);

        // Pointer fairness: grant 2, then 0101 wraps to 0 before 2.
        drive(1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 2);
        drive(1'b0, 4'b0100, 3'd0, 3'd0, 3'd4, 3'd0, 1);
        drive(1'b0, 4'b0101, 3'd1, 3'd0, 3'd4, 3'd0, 3);

        // Reset while a grant is pending.
        drive(1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 2);
        drive(1'b0, 4'b0100, 3'd0, 3'd0, 3'd2, 3'd0, 1);
        drive(1'b1, 4'b1111, 3'd1, 3'd2, 3'd4, 3'd5, 1);
        drive(1'b0, 4'b1111, 3'd1, 3'd2, 3'd4, 3'd5, 3);

        // Idle after a grant to address 5: rom_addr holds.
        drive(1'b0, 4'b0001, 3'd5, 3'd0, 3'd0, 3'd0, 1);
        drive(1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 4);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 49) == 0), R'($urandom),
                  AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), 1);
        end

        // Drain.
        drive(1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 4);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
